irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt aggregation and delivery stage directly upstream of the tile frontend.
- Collects 16 interrupt sources, latches them as pending, applies a mask and round-robin arbitration, and drives the frontend's `irqload`/`irqnum` pair.
- Delivers one interrupt at a time: a single-cycle `irqload` pulse, then an in-service wait for end-of-interrupt.
- A timeout and a holdoff throttle re-delivery.

Parameters:
- NSRC, 16, number of sources; fixed by the 4-bit `irqnum` width.
- HOLDOFF, 4, idle cycles enforced after each EOI or timeout before the next delivery; valid range 1..15.
- TIMEOUT, 1024, in-service cycles without `eoi` before the timeout fires; must be >= 2.
- TW, 11, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- irq_src  in  16  raw interrupt requests, synchronous to clk.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  2  register select: 0 mask, 1 edge-mode, 2 pending-clear (write-1-to-clear), 3 error-clear.
- cfg_wdata  in  16  configuration write data.
- eoi  in  1  end-of-interrupt from the core.
- irqload  out  1  one-cycle delivery pulse to the frontend.
- irqnum  out  4  delivered source number; valid while `irqload`=1 and held afterwards.
- busy  out  1  high in states LOAD, SERVICE and HOLD.
- pending  out  16  pending vector, unmasked view.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset, asynchronous:
  - All outputs 0.
  - mask=16'hFFFF (all masked), edge_mode=0, pending=0, src_r=0.
  - state=IDLE, last_winner=15, both counters 0.
  - Reset mid-SERVICE abandons delivery; no EOI is required afterwards.
- Input stage: `src_r` <= `irq_src` every cycle.
- Pending update, per bit i:
  - Edge mode: set on `src_r[i]` & ~`src_prev[i]`; `src_prev` is a second register stage.
  - Level mode: set while `src_r[i]`=1.
  - Cleared by a cfg_addr=2 write with bit=1.
  - Edge mode only: also cleared on entry to LOAD when i is the winner.
  - Set has priority over every clear in the same cycle.
- Mask does not gate pending. It gates arbitration only: eligible = pending & ~mask.
- Arbitration: round-robin. Search starts at (last_winner+1) mod 16 and wraps; the first eligible index wins. last_winner updates on entry to LOAD.
- State machine:
  - IDLE: if eligible≠0, go to LOAD and register `irqnum`=winner.
  - LOAD: `irqload`=1 for exactly this cycle; go to SERVICE and clear the timeout counter.
  - SERVICE:
    - Timeout counter increments each cycle.
    - `eoi`=1: go to HOLD with holdoff=HOLDOFF.
    - Otherwise, when the counter reaches TIMEOUT-1: set `timeout_err`, go to HOLD with holdoff=HOLDOFF.
    - `eoi` and timeout in the same cycle: treated as EOI; `timeout_err` is not set.
  - HOLD: decrement holdoff; when it is 1, go to IDLE.
- `eoi` is ignored outside SERVICE.
- Level source still high after service: re-pended and re-delivered after HOLD.
- Latency: edge first sampled into `src_r` at edge N → pending set at N+1 → LOAD at N+2. `irqload` is high between edges N+2 and N+3.
- Mask and edge-mode writes take effect the next cycle. They do not affect an interrupt already in LOAD or SERVICE.
- A cfg_addr=3 write with `cfg_wdata[0]`=1 clears `timeout_err`. A timeout in the same cycle wins.
- `irqnum` holds its last value until the next LOAD.

Decomposition:
- Package `irq_pkg`:
  - State enum {IDLE, LOAD, SERVICE, HOLD}.
  - Constants IRQ_CFG_MASK=0, IRQ_CFG_EDGE=1, IRQ_CFG_PCLR=2, IRQ_CFG_ECLR=3.
  - NSRC default.
- Sub-module `irq_rr_pick`: combinational round-robin picker.
  - Inputs: eligible[15:0], last[3:0].
  - Outputs: any, winner[3:0].

Test Plan:
1. Reset → all outputs 0, pending=0. With mask still FFFF, an edge on src 2 sets pending[2] but produces no `irqload`.
2. Write mask=0, edge_mode=FFFF; pulse src 5 sampled at edge N → `irqload`=1 only in cycle N+2 with `irqnum`=5; `busy`=1 until 4 cycles after `eoi`; pending[5]=0.
3. Edges on src 3 and 9 in the same cycle, last_winner=15 → deliver 3. After EOI+holdoff deliver 9. A new edge on 3 during 9's service is delivered next.
4. Level source 7 held high, edge_mode=0 → re-delivered after each EOI+HOLD. Set mask[7] during SERVICE → current service unaffected, no further delivery.
5. No `eoi` for 1024 cycles after LOAD → `timeout_err`=1, HOLD 4 cycles, IDLE. cfg_addr=3, wdata=1 → `timeout_err`=0. `eoi` on cycle 1023 → no error.
6. Assert `rst` asynchronously mid-SERVICE → `busy`/`irqload` drop immediately. After release, the first delivery searches from src 0.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared types and constants for the interrupt controller:
//               delivery state encoding, configuration register map and
//               default source count.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Default number of interrupt sources; tied to the 4-bit irqnum width.
    localparam int IRQ_NSRC = 16;

    // Configuration register select values (cfg_addr).
    localparam logic [1:0] IRQ_CFG_MASK = 2'd0;
    localparam logic [1:0] IRQ_CFG_EDGE = 2'd1;
    localparam logic [1:0] IRQ_CFG_PCLR = 2'd2;
    localparam logic [1:0] IRQ_CFG_ECLR = 2'd3;

    // Delivery state machine encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SERVICE = 2'd2,
        HOLD    = 2'd3
    } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : irq_rr_pick
// Description : Combinational round-robin picker. The search begins one
//               index after the previous winner and wraps, so the previous
//               winner itself has the lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_rr_pick
    import irq_pkg::*;
(
    input  logic [IRQ_NSRC-1:0] eligible,
    input  logic [3:0]          last,
    output logic                any,
    output logic [3:0]          winner
);

    logic [3:0] w_idx;

    // Scan from the farthest offset down to the nearest so the nearest
    // eligible index (in wrap order after last) is the final assignment.
    always_comb begin
        any    = 1'b0;
        winner = 4'd0;
        w_idx  = 4'd0;
        for (int k = IRQ_NSRC - 1; k >= 0; k--) begin
            w_idx = last + 4'(k + 1);
            if (eligible[w_idx]) begin
                any    = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Collects 16 interrupt sources into a pending vector, masks
//               and arbitrates them round-robin, and delivers one interrupt
//               at a time to the frontend as an irqload pulse plus irqnum.
//               Each delivery waits for eoi (or a timeout) and is followed
//               by a fixed holdoff before the next delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC    = IRQ_NSRC,
    parameter int HOLDOFF = 4,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [NSRC-1:0] cfg_wdata,
    input  logic            eoi,
    output logic            irqload,
    output logic [3:0]      irqnum,
    output logic            busy,
    output logic [NSRC-1:0] pending,
    output logic            timeout_err
);

    irq_state_t      r_state;
    irq_state_t      w_state_nxt;

    logic [NSRC-1:0] r_src;
    logic [NSRC-1:0] r_src_prev;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_edge_mode;
    logic [3:0]      r_last_winner;
    logic [3:0]      r_irqnum;
    logic [3:0]      r_holdoff;
    logic [TW-1:0]   r_tcnt;
    logic            r_timeout_err;

    logic [NSRC-1:0] w_eligible;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_clr;
    logic            w_any;
    logic [3:0]      w_winner;
    logic            w_enter_load;
    logic            w_enter_hold;
    logic            w_timeout_fire;

    // Mask only gates arbitration; pending stays visible unmasked.
    assign w_eligible = r_pending & ~r_mask;

    irq_rr_pick u_pick (
        .eligible (w_eligible),
        .last     (r_last_winner),
        .any      (w_any),
        .winner   (w_winner)
    );

    // Two-stage input register: r_src feeds level detection, r_src_prev
    // supplies the previous sample for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src      <= '0;
            r_src_prev <= '0;
        end else begin
            r_src      <= irq_src;
            r_src_prev <= r_src;
        end
    end

    // Per-source set condition depends on the source's edge/level mode.
    assign w_set = (r_edge_mode & r_src & ~r_src_prev) | (~r_edge_mode & r_src);

    // Clears: software write-1-to-clear, plus the winner in edge mode.
    always_comb begin
        w_clr = '0;
        if (cfg_we && (cfg_addr == IRQ_CFG_PCLR)) begin
            w_clr = cfg_wdata;
        end
        if (w_enter_load && r_edge_mode[w_winner]) begin
            w_clr[w_winner] = 1'b1;
        end
    end

    // Pending vector; a new set overrides any clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Mask and edge-mode configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask      <= '1;
            r_edge_mode <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == IRQ_CFG_MASK) begin
                r_mask <= cfg_wdata;
            end
            if (cfg_addr == IRQ_CFG_EDGE) begin
                r_edge_mode <= cfg_wdata;
            end
        end
    end

    // Delivery state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; eoi wins over a coincident timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_enter_load   = 1'b0;
        w_enter_hold   = 1'b0;
        w_timeout_fire = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt  = LOAD;
                    w_enter_load = 1'b1;
                end
            end
            LOAD: begin
                w_state_nxt = SERVICE;
            end
            SERVICE: begin
                if (eoi) begin
                    w_state_nxt  = HOLD;
                    w_enter_hold = 1'b1;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_state_nxt    = HOLD;
                    w_enter_hold   = 1'b1;
                    w_timeout_fire = 1'b1;
                end
            end
            HOLD: begin
                if (r_holdoff == 4'd1) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Service timeout counter and holdoff down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt    <= '0;
            r_holdoff <= 4'd0;
        end else begin
            if (r_state == LOAD) begin
                r_tcnt <= '0;
            end else if (r_state == SERVICE) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            if (w_enter_hold) begin
                r_holdoff <= 4'(HOLDOFF);
            end else if (r_state == HOLD) begin
                r_holdoff <= r_holdoff - 4'd1;
            end
        end
    end

    // Capture the winner on entry to LOAD; irqnum holds until the next LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irqnum      <= 4'd0;
            r_last_winner <= 4'd15;
        end else if (w_enter_load) begin
            r_irqnum      <= w_winner;
            r_last_winner <= w_winner;
        end
    end

    // Sticky timeout flag; a timeout beats a same-cycle software clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout_fire) begin
            r_timeout_err <= 1'b1;
        end else if (cfg_we && (cfg_addr == IRQ_CFG_ECLR) && cfg_wdata[0]) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign irqload     = (r_state == LOAD);
    assign busy        = (r_state != IDLE);
    assign irqnum      = r_irqnum;
    assign pending     = r_pending;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Self-checking bench for irq_ctrl. A timestamp-based model of
//               the delivery rules is compared with the DUT every cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam int HOLDOFF = 4;
    localparam int TIMEOUT = 1024;

    logic        clk;
    logic        rst;
    logic [15:0] irq_src;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        eoi;
    logic        irqload;
    logic [3:0]  irqnum;
    logic        busy;
    logic [15:0] pending;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    irq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .eoi         (eoi),
        .irqload     (irqload),
        .irqnum      (irqnum),
        .busy        (busy),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Delivery is tracked by timestamps: m_t counts clock edges, m_load_at is
    // the interval holding the irqload pulse, m_done_at the interval where the
    // post-service holdoff starts.
    logic [15:0] m_src, m_prev, m_pend, m_mask, m_edge;
    int          m_last, m_num, m_t, m_load_at, m_done_at;
    bit          m_svc, m_err;

    function automatic void m_reset();
        m_src = '0; m_prev = '0; m_pend = '0; m_mask = '1; m_edge = '0;
        m_last = 15; m_num = 0; m_t = 0; m_load_at = -1000; m_done_at = -1000;
        m_svc = 1'b0; m_err = 1'b0;
    endfunction

    function automatic bit m_busy();
        return m_svc || (m_t < m_done_at + HOLDOFF);
    endfunction

    function automatic bit m_load();
        return m_svc && (m_t == m_load_at);
    endfunction

    function automatic int rr_pick(input logic [15:0] el, input int last);
        for (int off = 1; off <= 16; off++) begin
            if (el[(last + off) % 16]) return (last + off) % 16;
        end
        return -1;
    endfunction

    initial begin : p_model
        logic [15:0] elig, setv, clrv;
        int          w;
        bit          errset;
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else begin
                elig   = m_pend & ~m_mask;
                setv   = (m_edge & m_src & ~m_prev) | (~m_edge & m_src);
                clrv   = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : 16'h0;
                errset = 1'b0;
                if (!m_busy() && elig != 0) begin
                    w         = rr_pick(elig, m_last);
                    m_load_at = m_t + 1;
                    m_svc     = 1'b1;
                    m_num     = w;
                    m_last    = w;
                    if (m_edge[w]) clrv[w] = 1'b1;
                end else if (m_svc && m_t > m_load_at) begin
                    if (eoi) begin
                        m_svc = 1'b0; m_done_at = m_t + 1;
                    end else if (m_t - m_load_at - 1 == TIMEOUT - 1) begin
                        m_svc = 1'b0; m_done_at = m_t + 1; errset = 1'b1;
                    end
                end
                m_pend = (m_pend & ~clrv) | setv;
                if (errset) m_err = 1'b1;
                else if (cfg_we && cfg_addr == 2'd3 && cfg_wdata[0]) m_err = 1'b0;
                if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
                if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata;
                m_prev = m_src;
                m_src  = irq_src;
                m_t++;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin : p_compare
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                check("irqload",     32'(irqload),     32'(m_load()));
                check("irqnum",      32'(irqnum),      32'(m_num));
                check("busy",        32'(busy),        32'(m_busy()));
                check("pending",     32'(pending),     32'(m_pend));
                check("timeout_err", 32'(timeout_err), 32'(m_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc();
        cfg_we = 1'b0; cfg_wdata = 16'h0;
    endtask

    task automatic pulse(input logic [15:0] s);
        irq_src = s;
        cyc();
        irq_src = 16'h0;
    endtask

    task automatic serve(input int n);
        cyc(n);
        eoi = 1'b1;
        cyc();
        eoi = 1'b0;
    endtask

    task automatic wait_load(input int budget, output int n);
        n = 0;
        while (irqload !== 1'b1 && n < budget) begin cyc(); n++; end
        check("wait_load", 32'(irqload), 32'd1);
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy !== 1'b0 && n < budget) begin cyc(); n++; end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : p_stim
        int n;
        int cnt;
        rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; eoi = 1'b0;
        #2;
        check("rst_irqload", 32'(irqload), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_irqnum",  32'(irqnum),  32'd0);
        check("rst_err",     32'(timeout_err), 32'd0);
        cyc(2);
        rst = 1'b0;

        // 1: everything masked -> pending set, no delivery
        pulse(16'h0004);
        cyc(3);
        check("t1_pending", 32'(pending), 32'h0004);
        check("t1_busy",    32'(busy),    32'd0);
        cfg(2'd2, 16'hFFFF);
        check("t1_pclr",    32'(pending), 32'h0000);

        // 2: single edge delivery latency and holdoff length
        cfg(2'd0, 16'h0000);
        cfg(2'd1, 16'hFFFF);
        irq_src = 16'h0020;
        cyc();
        irq_src = 16'h0;
        check("t2_load_n",   32'(irqload), 32'd0);
        cyc();
        check("t2_load_n1",  32'(irqload), 32'd0);
        check("t2_pend_n1",  32'(pending), 32'h0020);
        cyc();
        check("t2_load_n2",  32'(irqload), 32'd1);
        check("t2_num",      32'(irqnum),  32'd5);
        cyc();
        check("t2_load_n3",  32'(irqload), 32'd0);
        check("t2_busy_svc", 32'(busy),    32'd1);
        check("t2_pend_clr", 32'(pending), 32'h0000);
        cyc(2);
        eoi = 1'b1; cyc(); eoi = 1'b0;
        check("t2_busy_e",   32'(busy), 32'd1);
        cyc(3);
        check("t2_busy_e3",  32'(busy), 32'd1);
        cyc();
        check("t2_busy_e4",  32'(busy), 32'd0);

        // 3: round robin with last_winner = 15
        pulse(16'h8000);
        wait_load(10, n);
        check("t3_num15", 32'(irqnum), 32'd15);
        serve(2);
        wait_idle(20, n);
        pulse(16'h0208);
        wait_load(10, n);
        check("t3_first", 32'(irqnum), 32'd3);
        serve(2);
        wait_load(20, n);
        check("t3_second", 32'(irqnum), 32'd9);
        check("t3_gap",    32'(n),      32'd5);
        cyc();
        pulse(16'h0008);
        cyc(2);
        serve(0);
        wait_load(20, n);
        check("t3_third", 32'(irqnum), 32'd3);
        serve(1);
        wait_idle(20, n);

        // 4: level source re-delivery, then masked during service
        cfg(2'd1, 16'h0000);
        irq_src = 16'h0080;
        wait_load(10, n);
        check("t4_num", 32'(irqnum), 32'd7);
        serve(1);
        wait_load(20, n);
        check("t4_redeliver", 32'(irqnum), 32'd7);
        check("t4_gap",       32'(n),      32'd5);
        cyc();
        cfg(2'd0, 16'h0080);
        check("t4_busy_masked", 32'(busy), 32'd1);
        serve(2);
        wait_idle(20, n);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (irqload === 1'b1) cnt++;
        end
        check("t4_no_load", 32'(cnt),     32'd0);
        check("t4_pending", 32'(pending), 32'h0080);
        irq_src = 16'h0;
        cyc(2);
        cfg(2'd2, 16'hFFFF);
        cfg(2'd0, 16'h0000);
        cfg(2'd1, 16'hFFFF);
        check("t4_cleared", 32'(pending), 32'h0000);

        // 5: timeout, holdoff after timeout, error clear, eoi on last cycle
        pulse(16'h0002);
        wait_load(10, n);
        check("t5_num", 32'(irqnum), 32'd1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 1100) begin cyc(); n++; end
        check("t5_latency", 32'(n), 32'd1025);
        check("t5_err",     32'(timeout_err), 32'd1);
        wait_idle(10, n);
        check("t5_hold", 32'(n), 32'd4);
        cfg(2'd3, 16'h0001);
        check("t5_eclr", 32'(timeout_err), 32'd0);
        pulse(16'h0002);
        wait_load(10, n);
        cyc(1024);
        eoi = 1'b1; cyc(); eoi = 1'b0;
        check("t5_eoi_last_err",  32'(timeout_err), 32'd0);
        check("t5_eoi_last_busy", 32'(busy),        32'd1);
        wait_idle(10, n);

        // 6: asynchronous reset mid-service, search restarts at source 0
        pulse(16'h0400);
        wait_load(10, n);
        check("t6_num10", 32'(irqnum), 32'd10);
        cyc(3);
        #3 rst = 1'b1;
        #1;
        check("t6_busy_rst",    32'(busy),    32'd0);
        check("t6_irqload_rst", 32'(irqload), 32'd0);
        check("t6_irqnum_rst",  32'(irqnum),  32'd0);
        check("t6_pending_rst", 32'(pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cfg(2'd0, 16'h0000);
        cfg(2'd1, 16'hFFFF);
        pulse(16'h1004);
        wait_load(10, n);
        check("t6_first", 32'(irqnum), 32'd2);
        serve(1);
        wait_load(20, n);
        check("t6_second", 32'(irqnum), 32'd12);
        serve(1);
        wait_idle(20, n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
